// File: rtl/bcd_pkg.sv
// Shared widths and helpers for the BCD counter/scan blocks.
package bcd_pkg;
    localparam int              BCD_W      = 4;
    localparam int              DEC_W      = 10;
    localparam logic [BCD_W-1:0] BCD_MAX   = 4'd9;
    localparam int              MAX_DIGITS = 32;

    function automatic logic isBcd(input logic [BCD_W-1:0] nib);
        return nib <= BCD_MAX;
    endfunction

    function automatic logic [MAX_DIGITS-1:0] onehot(input int unsigned idx);
        return MAX_DIGITS'(1) << idx;
    endfunction
endpackage

// File: rtl/bcd_digit_cell.sv
// One BCD digit register; carry/borrow ripple to the next cell in the chain.
module bcd_digit_cell
    import bcd_pkg::*;
(
    input  logic             clk,
    input  logic             resetN,
    input  logic             clear,
    input  logic             load,
    input  logic [BCD_W-1:0] ldVal,
    input  logic             cin,
    input  logic             bin,
    output logic [BCD_W-1:0] q,
    output logic             cout,
    output logic             bout
);
    assign cout = cin & (q == BCD_MAX);
    assign bout = bin & (q == '0);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN)    q <= '0;
        else if (clear) q <= '0;
        else if (load)  q <= ldVal;
        else if (cin)   q <= (q == BCD_MAX) ? '0 : q + 1'b1;
        else if (bin)   q <= (q == '0) ? BCD_MAX : q - 1'b1;
    end
endmodule

// File: rtl/bcd_to_dec.sv
// Active-high BCD-to-decimal decoder; non-BCD codes decode to all-0.
module bcd_to_dec
    import bcd_pkg::*;
(
    input  logic [BCD_W-1:0] bcd,
    output logic [DEC_W-1:0] dec
);
    always_comb begin
        dec = '0;
        if (isBcd(bcd)) dec = DEC_W'(1) << bcd;
    end
endmodule

// File: rtl/bcd_scan_controller.sv
// Multi-digit BCD up/down counter with a time-multiplexed one-hot digit scan
// sharing a single BCD-to-decimal decoder.
module bcd_scan_controller
    import bcd_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 1000,
    parameter int BLANK_LZ = 0
) (
    input  logic                    clk,
    input  logic                    resetN,
    input  logic                    clear,
    input  logic                    load,
    input  logic [BCD_W*DIGITS-1:0] loadValue,
    input  logic                    countUp,
    input  logic                    countDown,
    output logic [BCD_W*DIGITS-1:0] value,
    output logic                    carry,
    output logic                    loadErr,
    output logic [DIGITS-1:0]       digitSel,
    output logic [DEC_W-1:0]        decOut
);
    localparam int IW = $clog2(DIGITS);
    localparam int PW = $clog2(SCAN_DIV);

    logic [DIGITS-1:0][BCD_W-1:0] dig, ldDig;
    logic [DIGITS:0]              cch, bch, hiZero;
    logic                         ldOk, ldAcc, upEn, dnEn;

    assign ldDig = loadValue;

    always_comb begin
        ldOk = 1'b1;
        for (int i = 0; i < DIGITS; i++)
            if (!isBcd(ldDig[i])) ldOk = 1'b0;
    end

    // Priority: clear > load > (up&down cancel) > up > down
    assign ldAcc  = load & ldOk & ~clear;
    assign upEn   = ~clear & ~load & countUp & ~countDown;
    assign dnEn   = ~clear & ~load & countDown & ~countUp;
    assign cch[0] = upEn;
    assign bch[0] = dnEn;
    assign hiZero[DIGITS] = 1'b1;

    for (genvar g = 0; g < DIGITS; g++) begin : g_dig
        bcd_digit_cell u_cell (
            .clk    (clk),
            .resetN (resetN),
            .clear  (clear),
            .load   (ldAcc),
            .ldVal  (ldDig[g]),
            .cin    (cch[g]),
            .bin    (bch[g]),
            .q      (dig[g]),
            .cout   (cch[g+1]),
            .bout   (bch[g+1])
        );
        assign hiZero[g] = hiZero[g+1] & (dig[g] == '0);
    end

    assign value = dig;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            carry   <= 1'b0;
            loadErr <= 1'b0;
        end else begin
            carry   <= cch[DIGITS] | bch[DIGITS];
            loadErr <= load & ~clear & ~ldOk;
        end
    end

    logic [PW-1:0] prescaler;
    logic [IW-1:0] scanIdx;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            prescaler <= '0;
            scanIdx   <= '0;
        end else if (prescaler == PW'(SCAN_DIV - 1)) begin
            prescaler <= '0;
            scanIdx   <= (scanIdx == IW'(DIGITS - 1)) ? '0 : scanIdx + 1'b1;
        end else begin
            prescaler <= prescaler + 1'b1;
        end
    end

    logic [BCD_W-1:0]      curDig;
    logic [DEC_W-1:0]      decRaw;
    logic [MAX_DIGITS-1:0] selOh;
    logic                  blank;

    assign curDig = dig[scanIdx];
    assign selOh  = onehot(32'(scanIdx));
    // Digit 0 always shows, so a zero count still displays "0".
    assign blank  = (BLANK_LZ != 0) && (scanIdx != '0) && hiZero[scanIdx];

    bcd_to_dec u_dec (
        .bcd (curDig),
        .dec (decRaw)
    );

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            digitSel <= '0;
            decOut   <= '0;
        end else begin
            digitSel <= selOh[DIGITS-1:0];
            decOut   <= blank ? '0 : decRaw;
        end
    end
endmodule
